mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single read/write data port (port 1) of the sparse dual-port memory between two requesters: requester 0 is the CPU data port and requester 1 is the DMA/program loader.
- Sits between the requesters and the memory's en1/wen1/addr1/din1/dout1 pins. Port 0, the instruction fetch port, is untouched.
- Provides a req/gnt handshake, round-robin arbitration, locked bursts with a forced-release limit, and read-return steering with a one-cycle latency.

Parameters:
- AW, 30, word address width; matches the 30-bit word address used by the memory.
- DW, 32, data width.
- MAX_BURST, 8, maximum beats one locked owner may take before forced release (2..255).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  2  per-requester access request, index 0 = CPU, 1 = DMA.
- lock  in  2  per-requester burst lock; sampled only on a granted beat.
- we  in  2  per-requester write enable (1 = write, 0 = read).
- addr0  in  AW  requester 0 word address.
- addr1  in  AW  requester 1 word address.
- wdata0  in  DW  requester 0 write data.
- wdata1  in  DW  requester 1 write data.
- gnt  out  2  one-hot or zero; same-cycle acceptance of the request.
- rvalid  out  2  read data valid for the requester, one cycle after its granted read.
- rdata  out  DW  read data, shared by both requesters; qualify with rvalid.
- mem_en  out  1  memory port enable.
- mem_wen  out  1  memory port write enable.
- mem_addr  out  AW  memory port address.
- mem_wdata  out  DW  memory port write data.
- mem_rdata  in  DW  memory port read data; registered in memory, valid the cycle after the access.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; rr_last=1, so requester 0 wins the first tie; burst_cnt=0; rvalid=0.
  - While in reset: gnt=0, mem_en=0, mem_wen=0.
  - mem_addr and mem_wdata are don't-care while in reset.
- gnt is combinational from req, state and rr_last. The beat completes in the granted cycle. A requester holds req/we/addr/wdata stable until gnt.
- Memory drive:
  - mem_en=|gnt.
  - mem_wen = we[granted] & mem_en.
  - mem_addr and mem_wdata are muxed from the granted requester, and from requester 0 when nothing is granted.
- Read return: rvalid[i] = registered (gnt[i] & ~we[i]). rdata = mem_rdata, passed through combinationally. Writes never raise rvalid.
- States:
  - IDLE (no owner):
    - Single request: grant it.
    - Both requesting: grant the index != rr_last.
    - Each grant updates rr_last to the granted index.
    - Granted beat with lock[i]=1: go to LOCKi with burst_cnt=1.
  - LOCKi:
    - Only requester i may be granted. The other is stalled regardless of its req.
    - No req[i]: no grant, stay in LOCKi, burst_cnt holds.
    - Granted beat with lock[i]=0: last beat; go to IDLE.
    - Granted beat with lock[i]=1 and burst_cnt==MAX_BURST-1: forced release; that beat is granted, then go to IDLE.
    - Otherwise, on a granted beat: burst_cnt+1.
    - After a forced release with the other requester pending, the other requester wins next, because rr_last=i.
  - A locked burst is therefore at most MAX_BURST beats. burst_cnt width is clog2(MAX_BURST+1).
- Boundaries:
  - Simultaneous requests in IDLE alternate every beat when neither locks.
  - A requester dropping req while its lock is held keeps ownership (no timeout).
  - Reset mid-burst returns to IDLE and clears any pending rvalid.
  - Write followed by a read of the same address on consecutive beats returns the new data, because the memory is write-first on port 1.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef arb_state_t {IDLE, LOCK0, LOCK1};
  - constants REQ_CPU=0 and REQ_DMA=1.
- Sub-module rr_pick2 holds the 2-way round-robin selection (req[1:0], last → gnt one-hot). This keeps the FSM and the datapath mux in the top module.

Test Plan:
- After reset: req=2'b11, lock=0, both reading addr 0x10 / 0x20 for 4 cycles → gnt sequence 01,10,01,10; rvalid follows each gnt one cycle later; rdata matches preloaded mem[0x10] / mem[0x20].
- DMA locked burst: req[1]=1, lock[1]=1 for 3 beats writing 0xA0..0xA2, with CPU req held throughout → CPU gnt=0 for all 3 beats; lock[1] drops on the 4th beat → CPU granted on the cycle after the 4th beat.
- Forced release with MAX_BURST=8: DMA holds lock=1 with req=1 continuously while CPU requests → exactly 8 DMA grants, then CPU granted; DMA granted again afterwards.
- Write-then-read: CPU writes 0xDEADBEEF to 0x3FF, then reads 0x3FF on the next beat → rvalid[0]=1 with rdata=0xDEADBEEF; rvalid[0]=0 for the write beat.
- Reset mid-burst: drop rst during LOCK1 after 2 beats → gnt=0, mem_en=0 immediately; after release, CPU alone is granted first.
- Idle ownership: LOCK0 entered, CPU drops req for 5 cycles while DMA requests → no grants for those 5 cycles, burst_cnt unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port-1 arbiter.
//   arb_state_t : arbiter ownership state (no owner, or locked to one requester)
//   REQ_CPU     : requester index of the CPU data port
//   REQ_DMA     : requester index of the DMA / program loader
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick.
//   req  : request vector, index 0 = CPU, 1 = DMA
//   last : index granted most recently; loses a tie
//   gnt  : one-hot grant, or zero when nobody requests
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the read/write port of the dual-port memory between the
// CPU data port (requester 0) and the DMA/program loader (requester 1).
// Round-robin between requesters, locked bursts capped at MAX_BURST beats,
// and read-return steering one cycle after the granted read.
//   clk, rst            : clock, asynchronous active-low reset
//   req, lock, we       : per-requester request, burst lock, write enable
//   addr0/1, wdata0/1   : per-requester word address and write data
//   gnt                 : same-cycle one-hot grant (zero when none)
//   rvalid, rdata       : read return, rdata shared and qualified by rvalid
//   mem_en/wen/addr/wdata, mem_rdata : memory port pins
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = 30,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [1:0]    lock,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t    state, state_nxt;
  logic          rr_last, rr_last_nxt;
  logic [CW-1:0] burst_cnt, burst_cnt_nxt;
  logic [1:0]    rr_gnt;
  logic [1:0]    rvalid_p1;
  logic          gidx;

  rr_pick2 u_pick (
    .req  (req),
    .last (rr_last),
    .gnt  (rr_gnt)
  );

  // Grant is combinational; gated by reset so nothing reaches the memory
  // while rst is low, even before the first clock edge.
  always_comb begin
    gnt = 2'b00;
    case (state)
      IDLE:    gnt = rr_gnt;
      LOCK0:   gnt[REQ_CPU] = req[REQ_CPU];
      LOCK1:   gnt[REQ_DMA] = req[REQ_DMA];
      default: gnt = 2'b00;
    endcase
    if (!rst) begin
      gnt = 2'b00;
    end
  end

  // With no grant gidx is 0, so the address/data mux defaults to requester 0.
  assign gidx      = gnt[REQ_DMA];
  assign mem_en    = |gnt;
  assign mem_wen   = mem_en & we[gidx];
  assign mem_addr  = gidx ? addr1 : addr0;
  assign mem_wdata = gidx ? wdata1 : wdata0;
  assign rdata     = mem_rdata;
  assign rvalid    = rvalid_p1;

  always_comb begin
    state_nxt     = state;
    rr_last_nxt   = rr_last;
    burst_cnt_nxt = burst_cnt;
    if (mem_en) begin
      rr_last_nxt = gidx;
      case (state)
        IDLE: begin
          if (lock[gidx]) begin
            state_nxt     = gidx ? LOCK1 : LOCK0;
            burst_cnt_nxt = CW'(1);
          end
        end
        default: begin
          // burst_cnt counts beats already taken, so reaching MAX_BURST-1
          // here means this beat is the MAX_BURST-th one.
          if (!lock[gidx] || burst_cnt == CW'(MAX_BURST - 1)) begin
            state_nxt     = IDLE;
            burst_cnt_nxt = '0;
          end else begin
            burst_cnt_nxt = burst_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // p0 -> p1: granted beat registered; read return valid one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_last   <= 1'b1;
      burst_cnt <= '0;
      rvalid_p1 <= 2'b00;
    end else begin
      state     <= state_nxt;
      rr_last   <= rr_last_nxt;
      burst_cnt <= burst_cnt_nxt;
      rvalid_p1 <= gnt & ~we;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req, lock, we;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    gnt, rvalid;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Write-first memory behind port 1 (environment, not the reference).
  logic [DW-1:0] emem [logic [AW-1:0]];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wen) begin
        emem[mem_addr] = mem_wdata;
        mem_rdata <= mem_wdata;
      end else begin
        mem_rdata <= emem.exists(mem_addr) ? emem[mem_addr] : '0;
      end
    end
  end

  // Reference: who owns the port, how many beats it has used, who won last.
  int            m_owner = -1;
  int            m_beats = 0;
  int            m_last  = 1;
  logic [1:0]    m_rv    = 2'b00;
  logic [DW-1:0] m_rd    = '0;
  logic [DW-1:0] mm [logic [AW-1:0]];

  always @(negedge clk) begin
    logic [1:0]    eg;
    int            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (!rst) begin
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_mem_wen", mem_wen, 1'b0);
      chk("rst_rvalid", rvalid, 2'b00);
      m_owner = -1; m_beats = 0; m_last = 1; m_rv = 2'b00;
    end else begin
      if (m_owner >= 0)      eg = req[m_owner] ? 2'(1 << m_owner) : 2'b00;
      else if (req == 2'b11) eg = 2'(1 << (1 - m_last));
      else                   eg = req;
      w = eg[1] ? 1 : 0;
      a = (w == 1) ? addr1 : addr0;
      d = (w == 1) ? wdata1 : wdata0;
      chk("gnt", gnt, eg);
      chk("mem_en", mem_en, |eg);
      chk("mem_wen", mem_wen, (|eg) & we[w]);
      chk("mem_addr", mem_addr, a);
      chk("mem_wdata", mem_wdata, d);
      chk("rvalid", rvalid, m_rv);
      if (m_rv != 2'b00) chk("rdata", rdata, m_rd);
      m_rv = 2'b00;
      if (eg != 2'b00) begin
        if (we[w]) mm[a] = d;
        else begin
          m_rv = eg;
          m_rd = mm.exists(a) ? mm[a] : '0;
        end
        m_last = w;
        if (m_owner < 0) begin
          if (lock[w]) begin m_owner = w; m_beats = 1; end
        end else begin
          m_beats++;
          if (!lock[w] || m_beats == MB) m_owner = -1;
        end
      end
    end
  end

  logic [1:0]    g, rv;
  logic [DW-1:0] rd;

  task automatic step(output logic [1:0] og, output logic [1:0] orv, output logic [DW-1:0] ord);
    @(negedge clk);
    og = gnt; orv = rvalid; ord = rdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    rst = 1'b0; req = 0; lock = 0; we = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    emem[30'h10] = 32'h1111_1111; mm[30'h10] = 32'h1111_1111;
    emem[30'h20] = 32'h2222_2222; mm[30'h20] = 32'h2222_2222;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Alternating reads with both requesting
    req = 2'b11; addr0 = 30'h10; addr1 = 30'h20;
    for (int k = 0; k < 4; k++) begin
      step(g, rv, rd);
      chk("t1_gnt", g, (k % 2) ? 2'b10 : 2'b01);
      if (k > 0) begin
        chk("t1_rvalid", rv, (k % 2) ? 2'b01 : 2'b10);
        chk("t1_rdata", rd, (k % 2) ? 32'h1111_1111 : 32'h2222_2222);
      end
    end
    req = 2'b00;
    step(g, rv, rd);
    chk("t1_rvalid_last", rv, 2'b10);
    chk("t1_rdata_last", rd, 32'h2222_2222);

    // DMA locked burst with CPU held off
    req = 2'b01;
    step(g, rv, rd);
    chk("t2_cpu_first", g, 2'b01);
    req = 2'b11; lock = 2'b10; we = 2'b10;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) lock = 2'b00;
      addr1 = 30'hA0 + 30'(k); wdata1 = 32'hA0 + 32'(k);
      step(g, rv, rd);
      chk("t2_dma_beat", g, 2'b10);
    end
    step(g, rv, rd);
    chk("t2_cpu_after", g, 2'b01);
    req = 2'b00;
    step(g, rv, rd);

    // Forced release after MAX_BURST beats
    req = 2'b11; lock = 2'b10; we = 2'b10; addr1 = 30'h100; wdata1 = 32'h5555_0000;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step(g, rv, rd);
      if (g == 2'b10) cnt++;
      else break;
    end
    chk("t3_dma_beats", cnt, MB);
    chk("t3_cpu_gnt", g, 2'b01);
    step(g, rv, rd);
    chk("t3_dma_again", g, 2'b10);
    req = 2'b10; lock = 2'b00;
    step(g, rv, rd);
    req = 2'b00;
    step(g, rv, rd);

    // Write then read of the same word
    req = 2'b01; we = 2'b01; lock = 2'b00; addr0 = 30'h3FF; wdata0 = 32'hDEAD_BEEF;
    step(g, rv, rd);
    chk("t4_wr_gnt", g, 2'b01);
    we = 2'b00;
    step(g, rv, rd);
    chk("t4_rd_gnt", g, 2'b01);
    chk("t4_no_rvalid_wr", rv[0], 1'b0);
    req = 2'b00;
    step(g, rv, rd);
    chk("t4_rvalid", rv[0], 1'b1);
    chk("t4_rdata", rd, 32'hDEAD_BEEF);

    // Reset in the middle of a DMA burst
    req = 2'b10; lock = 2'b10; we = 2'b00; addr1 = 30'h20;
    step(g, rv, rd); chk("t5_beat1", g, 2'b10);
    step(g, rv, rd); chk("t5_beat2", g, 2'b10);
    req = 2'b11;
    rst = 1'b0;
    #1;
    chk("t5_gnt_now", gnt, 2'b00);
    chk("t5_en_now", mem_en, 1'b0);
    chk("t5_rvalid_now", rvalid, 2'b00);
    step(g, rv, rd);
    step(g, rv, rd);
    rst = 1'b1; lock = 2'b00;
    step(g, rv, rd);
    chk("t5_cpu_first", g, 2'b01);
    req = 2'b00;
    step(g, rv, rd);

    // Owner idles while holding the lock
    req = 2'b01; lock = 2'b01; addr0 = 30'h10;
    step(g, rv, rd);
    chk("t6_lock_gnt", g, 2'b01);
    req = 2'b10; lock = 2'b11;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step(g, rv, rd);
      if (g != 2'b00) cnt++;
    end
    chk("t6_idle_grants", cnt, 0);
    req = 2'b11; lock = 2'b01;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step(g, rv, rd);
      if (g == 2'b01) cnt++;
      else break;
    end
    chk("t6_cpu_rest", cnt, MB - 1);
    chk("t6_dma_next", g, 2'b10);
    req = 2'b00; lock = 2'b00;
    step(g, rv, rd);
    step(g, rv, rd);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
